// File: rtl/weight_buffer_sink.sv
// weight_buffer_sink: runtime-loadable weight store with a ROM-compatible read port.
// Purpose: accepts a weight tensor as valid/ready beats (one beat per RAM word) and
//   serves it back through the address0/ce0/q0 interface used by the generated
//   weight ROMs, with 2 ce0-enabled cycles of read latency.
// Ports:
//   clk, rst          clock (rising edge); synchronous active-low reset
//   data_in[P0*P1]    beat elements; element j lands at word bits [PREC*j +: PREC]
//   data_in_valid     beat valid
//   data_in_ready     beat ready (low while rst is low or a full tensor is held)
//   reload            single-cycle pulse: drop stored tensor and restart loading
//   load_done         high while a complete tensor is stored
//   address0, ce0     read address and read pipeline enable
//   q0                read data (zero for address0 >= DEPTH)
//   checksum          running sign-extended element sum of the loaded tensor
// Optional feature macro: WEIGHT_SINK_CHECKSUM_EN (undefined: checksum tied to 0).
module weight_buffer_sink #(
  parameter int unsigned WEIGHT_PRECISION_0       = 16,
  parameter int unsigned WEIGHT_TENSOR_SIZE_DIM_0 = 32,
  parameter int unsigned WEIGHT_TENSOR_SIZE_DIM_1 = 1,
  parameter int unsigned WEIGHT_PARALLELISM_DIM_0 = 4,
  parameter int unsigned WEIGHT_PARALLELISM_DIM_1 = 1,
  parameter int unsigned DEPTH = (WEIGHT_TENSOR_SIZE_DIM_0 * WEIGHT_TENSOR_SIZE_DIM_1) /
                                 (WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1),
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WEIGHT_PRECISION_0-1:0] data_in [WEIGHT_PARALLELISM_DIM_0*WEIGHT_PARALLELISM_DIM_1],
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  input  logic                          reload,
  output logic                          load_done,
  input  logic [ADDR_WIDTH-1:0]         address0,
  input  logic                          ce0,
  output logic [WEIGHT_PRECISION_0*WEIGHT_PARALLELISM_DIM_0*WEIGHT_PARALLELISM_DIM_1-1:0] q0,
  output logic [31:0]                   checksum
);

  localparam int unsigned PREC     = WEIGHT_PRECISION_0;
  localparam int unsigned NUM_ELEM = WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1;
  localparam int unsigned WORD_W   = PREC * NUM_ELEM;
  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    S_LOAD = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   w_wr_ptr_nxt;
  logic               w_accept;
  logic               w_last;
  logic [WORD_W-1:0]  w_wr_word;
  logic [WORD_W-1:0]  r_ram [DEPTH];
  logic               w_rd_oor;
  logic [PTR_W-1:0]   w_rd_idx;
  logic [WORD_W-1:0]  r_stage0;
  logic [WORD_W-1:0]  r_stage1;
  logic               r_oor0;

  // Handshake: ready only in LOAD and never while reset is asserted
  assign data_in_ready = rst & (r_state == S_LOAD);
  assign load_done     = (r_state == S_FULL);
  assign w_accept      = data_in_valid & data_in_ready;
  assign w_last        = (r_wr_ptr == PTR_W'(DEPTH - 1));

  // Pack beat elements into one RAM word
  always_comb begin
    w_wr_word = '0;
    for (int j = 0; j < int'(NUM_ELEM); j++) begin
      w_wr_word[PREC*j +: PREC] = data_in[j];
    end
  end

  // Next state / write pointer; reload overrides the last-beat FULL transition
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    case (r_state)
      S_LOAD: begin
        if (w_accept) begin
          if (w_last) begin
            w_wr_ptr_nxt = '0;
            w_state_nxt  = S_FULL;
          end else begin
            w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
          end
        end
      end
      S_FULL: begin
        w_state_nxt = S_FULL;
      end
      default: begin
        w_state_nxt = S_LOAD;
      end
    endcase
    if (reload) begin
      w_state_nxt  = S_LOAD;
      w_wr_ptr_nxt = '0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_LOAD;
      r_wr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
    end
  end

  // Storage; not cleared by reset. A beat accepted alongside reload is still written.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_ram[r_wr_ptr] <= w_wr_word;
    end
  end

  // Out-of-range reads index word 0 harmlessly and are zeroed via the pipelined flag
  assign w_rd_oor = (address0 >= ADDR_WIDTH'(DEPTH));
  assign w_rd_idx = w_rd_oor ? '0 : address0[PTR_W-1:0];

  // Two-stage read pipeline; nonblocking RAM read gives read-first on collision
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stage0 <= '0;
      r_stage1 <= '0;
      r_oor0   <= 1'b0;
    end else if (ce0) begin
      r_stage0 <= r_ram[w_rd_idx];
      r_oor0   <= w_rd_oor;
      r_stage1 <= r_oor0 ? '0 : r_stage0;
    end
  end

  assign q0 = r_stage1;

`ifdef WEIGHT_SINK_CHECKSUM_EN
  logic [31:0] w_beat_sum;
  logic [31:0] r_checksum;

  // Sign-extended sum of the current beat's elements
  always_comb begin
    w_beat_sum = '0;
    for (int j = 0; j < int'(NUM_ELEM); j++) begin
      w_beat_sum = w_beat_sum + 32'($signed(data_in[j]));
    end
  end

  // Beats coinciding with reload are not counted
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_checksum <= '0;
    end else if (reload) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + w_beat_sum;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_weight_buffer_sink.sv
// Scoreboard bench for weight_buffer_sink: a driver issues random beats/reads and
// pushes expected read words; a monitor pops them as the read pipeline delivers.
module tb_weight_buffer_sink;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned NE    = 4;
  localparam int unsigned AW    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in [NE];
  logic        data_in_valid;
  logic        data_in_ready;
  logic        reload;
  logic        load_done;
  logic [AW-1:0] address0;
  logic        ce0;
  logic [63:0] q0;
  logic [31:0] checksum;

  weight_buffer_sink dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .reload(reload), .load_done(load_done),
    .address0(address0), .ce0(ce0), .q0(q0), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: stored words, beats received so far, full flag, element sum
  logic [63:0] m_mem [DEPTH];
  int          m_ptr = 0;
  bit          m_full = 1'b0;
  logic [31:0] m_sum = '0;
  logic [15:0] d [NE];
  logic [63:0] q_exp [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack_beat();
    logic [63:0] w;
    for (int j = 0; j < int'(NE); j++) w[16*j +: 16] = d[j];
    return w;
  endfunction

  function automatic logic [15:0] gen(input int mode, input int b, input int j);
    case (mode)
      0: return 16'(b*4 + j);
      1: return 16'h00AA;
      3: return (b == 0 && j == 0) ? 16'hFFFF : 16'(b*4 + j);
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] exp_ck();
`ifdef WEIGHT_SINK_CHECKSUM_EN
    return m_sum;
`else
    return 32'd0;
`endif
  endfunction

  // Tensor-level model: count received beats, a full tensor is DEPTH counted beats
  task automatic model_update(input bit v, input bit rl);
    bit acc;
    if (!rst) begin
      m_ptr = 0; m_full = 1'b0; m_sum = '0;
    end else begin
      acc = v && !m_full;
      if (acc) m_mem[m_ptr] = pack_beat();
      if (rl) begin
        m_ptr = 0; m_full = 1'b0; m_sum = '0;
      end else if (acc) begin
        for (int j = 0; j < int'(NE); j++) m_sum = m_sum + 32'($signed(d[j]));
        m_ptr++;
        if (m_ptr == int'(DEPTH)) begin
          m_ptr = 0; m_full = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle(input bit v, input bit rl, input int addr, input bit ce);
    data_in_valid = v;
    reload        = rl;
    address0      = AW'(addr);
    ce0           = ce;
    data_in       = d;
    if (ce && rst) q_exp.push_back((addr < int'(DEPTH)) ? m_mem[addr] : 64'd0);
    @(posedge clk);
    model_update(v, rl);
    #1;
    chk("ready", 64'(data_in_ready), 64'(rst && !m_full));
    chk("load_done", 64'(load_done), 64'(m_full));
    chk("checksum", 64'(checksum), 64'(exp_ck()));
  endtask

  task automatic set_beat(input int mode);
    for (int j = 0; j < int'(NE); j++) d[j] = gen(mode, m_ptr, j);
  endtask

  // Load until full with random valid; reads (optional) often collide with the write slot
  task automatic load(input int mode, input int pct, input bit rd);
    int n = 0;
    int a;
    while (!m_full && n < 300) begin
      set_beat(mode);
      a = ($urandom_range(1) == 1) ? m_ptr : int'($urandom_range(DEPTH + 1));
      cycle($urandom_range(99) < pct, 1'b0, a, rd && ($urandom_range(1) == 1));
      n++;
    end
    if (!m_full) begin
      n_cmp++; n_bad++;
      $display("FAIL load_timeout: got not-full expected full after %0d cycles", n);
    end
  endtask

  task automatic rd_burst(input int n);
    for (int i = 0; i < n; i++)
      cycle($urandom_range(1) == 1, 1'b0, int'($urandom_range(DEPTH + 1)), $urandom_range(3) != 0);
  endtask

  // Monitor: a word issued with ce0 appears on q0 after two enabled edges
  initial begin
    logic [63:0] inflight [$];
    logic [63:0] e;
    forever begin
      @(posedge clk);
      if (!rst) begin
        inflight.delete();
      end else if (ce0) begin
        if (q_exp.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_empty: got read with no expectation at %0t", $time);
        end else begin
          inflight.push_back(q_exp.pop_front());
        end
        if (inflight.size() >= 2) begin
          e = inflight.pop_front();
          #1 chk("q0", q0, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int j = 0; j < int'(NE); j++) d[j] = '0;
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
    rst = 1'b0;
    // Reset
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0, 1'b0);
    chk("rst_q0", q0, 64'd0);
    rst = 1'b1;

    // Ramp tensor, valid held high
    load(0, 100, 1'b0);
    chk("ramp_done", 64'(load_done), 64'd1);
    chk("ramp_ck", 64'(checksum),
`ifdef WEIGHT_SINK_CHECKSUM_EN
        64'd496
`else
        64'd0
`endif
    );

    // Direct reads: address 5, address 8, address 3 with ce0 gap
    cycle(1'b0, 1'b0, 5, 1'b1);
    cycle(1'b0, 1'b0, 8, 1'b1);
    chk("addr5", q0, 64'h0017_0016_0015_0014);
    cycle(1'b0, 1'b0, 3, 1'b1);
    chk("addr8", q0, 64'd0);
    cycle(1'b0, 1'b0, 8, 1'b0);
    cycle(1'b0, 1'b0, 8, 1'b0);
    chk("ce0_hold", q0, 64'd0);
    cycle(1'b0, 1'b0, 8, 1'b1);
    chk("addr3", q0, 64'h000F_000E_000D_000C);

    // FULL ignores valid for 10 cycles
    for (int i = 0; i < 10; i++) begin
      d[0] = 16'($urandom);
      cycle(1'b1, 1'b0, int'($urandom_range(DEPTH)), 1'b1);
    end
    chk("full_ready", 64'(data_in_ready), 64'd0);
    rd_burst(12);

    // Reload in FULL, load constant 0x00AA tensor with toggling valid
    cycle(1'b0, 1'b1, 0, 1'b0);
    chk("reload_drop", 64'(load_done), 64'd0);
    load(1, 50, 1'b1);
    for (int a = 0; a <= int'(DEPTH); a++) cycle(1'b0, 1'b0, a, 1'b1);
    rd_burst(10);

    // Tensor with a -1 element for sign extension
    cycle(1'b0, 1'b1, 0, 1'b0);
    load(3, 60, 1'b1);
    chk("neg_ck", 64'(checksum),
`ifdef WEIGHT_SINK_CHECKSUM_EN
        64'd495
`else
        64'd0
`endif
    );
    rd_burst(10);

    // reload coinciding with the 8th beat
    cycle(1'b0, 1'b1, 0, 1'b0);
    for (int b = 0; b < 7; b++) begin
      set_beat(2);
      cycle(1'b1, 1'b0, int'($urandom_range(DEPTH)), 1'b1);
    end
    set_beat(2);
    cycle(1'b1, 1'b1, 7, 1'b1);
    chk("coinc_done", 64'(load_done), 64'd0);
    for (int b = 0; b < 7; b++) begin
      set_beat(0);
      cycle(1'b1, 1'b0, int'($urandom_range(DEPTH)), 1'b1);
    end
    chk("coinc_7", 64'(load_done), 64'd0);
    set_beat(0);
    cycle(1'b1, 1'b0, 0, 1'b1);
    chk("coinc_8", 64'(load_done), 64'd1);
    rd_burst(10);

    // Reset mid-load, then a random tensor
    cycle(1'b0, 1'b1, 0, 1'b0);
    for (int b = 0; b < 3; b++) begin
      set_beat(2);
      cycle(1'b1, 1'b0, 0, 1'b0);
    end
    rst = 1'b0;
    cycle(1'b1, 1'b0, 0, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b0);
    rst = 1'b1;
    chk("midrst_done", 64'(load_done), 64'd0);
    load(2, 70, 1'b1);
    rd_burst(20);

    // Drain the read pipeline
    cycle(1'b0, 1'b0, 8, 1'b1);
    cycle(1'b0, 1'b0, 8, 1'b1);
    ce0 = 1'b0;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
